// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded instruction and control from ID, registered copies toward EX.
// Carries no state of its own; the stage register adds one cycle between the id_* and ex_* groups.
// Backpressure travels as ex_hold_i into the stage and id_stall_o back out toward IF/ID.
`ifndef INST_ID_LEN
`define INST_ID_LEN 6
`endif

interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // Decode-side instruction and control-unit enables
    logic                    id_valid_i;
    logic [XLEN-1:0]         id_pc_i;
    logic [4:0]              id_rs1_addr_i;
    logic [4:0]              id_rs2_addr_i;
    logic [4:0]              id_rd_addr_i;
    logic [XLEN-1:0]         id_rs1_data_i;
    logic [XLEN-1:0]         id_rs2_data_i;
    logic [XLEN-1:0]         id_imm_i;
    logic [`INST_ID_LEN-1:0] id_instr_id_i;
    logic                    id_rs1_re_i;
    logic                    id_rs2_re_i;
    logic                    id_rd_we_i;
    logic                    id_mem_re_i;
    logic                    id_mem_we_i;

    // Pipeline control
    logic                    ex_hold_i;
    logic                    flush_i;
    logic                    id_stall_o;

    // Execute-side registered copies
    logic                    ex_valid_o;
    logic [XLEN-1:0]         ex_pc_o;
    logic [4:0]              ex_rs1_addr_o;
    logic [4:0]              ex_rs2_addr_o;
    logic [4:0]              ex_rd_addr_o;
    logic [XLEN-1:0]         ex_rs1_data_o;
    logic [XLEN-1:0]         ex_rs2_data_o;
    logic [XLEN-1:0]         ex_imm_o;
    logic [`INST_ID_LEN-1:0] ex_instr_id_o;
    logic                    ex_rs1_re_o;
    logic                    ex_rs2_re_o;
    logic                    ex_rd_we_o;
    logic                    ex_mem_re_o;
    logic                    ex_mem_we_o;

    logic [CNT_W-1:0]        bubble_cnt_o;

    // Driver side (decode stage / bench)
    modport master (
        output id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_instr_id_i,
               id_rs1_re_i, id_rs2_re_i, id_rd_we_i, id_mem_re_i, id_mem_we_i,
               ex_hold_i, flush_i,
        input  id_stall_o,
               ex_valid_o, ex_pc_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
               ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_instr_id_o,
               ex_rs1_re_o, ex_rs2_re_o, ex_rd_we_o, ex_mem_re_o, ex_mem_we_o,
               bubble_cnt_o
    );

    // Stage register side
    modport slave (
        input  id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_instr_id_i,
               id_rs1_re_i, id_rs2_re_i, id_rd_we_i, id_mem_re_i, id_mem_we_i,
               ex_hold_i, flush_i,
        output id_stall_o,
               ex_valid_o, ex_pc_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
               ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_instr_id_o,
               ex_rs1_re_o, ex_rs2_re_o, ex_rd_we_o, ex_mem_re_o, ex_mem_we_o,
               bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, flush bubble and saturating bubble counter.
// Latency: ID fields appear on ex_* one cycle after the accepting edge.
// Backpressure: ex_hold_i freezes the register; id_stall_o (combinational) holds IF/ID on hold or load-use.
`ifndef INST_ID_LEN
`define INST_ID_LEN 6
`endif

module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic cnt_sat;
    logic bubble;

    // Hazard when the ID instruction reads the destination of a load sitting in EX
    always_comb begin
        rs1_hit  = bus.id_rs1_re_i && (bus.id_rs1_addr_i == bus.ex_rd_addr_o);
        rs2_hit  = bus.id_rs2_re_i && (bus.id_rs2_addr_i == bus.ex_rd_addr_o);
        load_use = bus.ex_valid_o && bus.ex_mem_re_o && (bus.ex_rd_addr_o != 5'd0) &&
                   bus.id_valid_i && (rs1_hit || rs2_hit);
        cnt_sat  = &bus.bubble_cnt_o;
        // Flush, load-use and an empty ID slot all produce the same bubble
        bubble   = bus.flush_i || load_use || !bus.id_valid_i;
    end

    // A flush kills the dependent instruction, so it never needs to wait
    assign bus.id_stall_o = bus.ex_hold_i || (load_use && !bus.flush_i);

    // Stage register: reset, then hold, then bubble, else accept ID
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ex_valid_o    <= 1'b0;
            bus.ex_pc_o       <= '0;
            bus.ex_rs1_addr_o <= '0;
            bus.ex_rs2_addr_o <= '0;
            bus.ex_rd_addr_o  <= '0;
            bus.ex_rs1_data_o <= '0;
            bus.ex_rs2_data_o <= '0;
            bus.ex_imm_o      <= '0;
            bus.ex_instr_id_o <= '0;
            bus.ex_rs1_re_o   <= 1'b0;
            bus.ex_rs2_re_o   <= 1'b0;
            bus.ex_rd_we_o    <= 1'b0;
            bus.ex_mem_re_o   <= 1'b0;
            bus.ex_mem_we_o   <= 1'b0;
            bus.bubble_cnt_o  <= '0;
        end else if (!bus.ex_hold_i) begin
            if (bubble) begin
                // Only control fields are cleared; data/address/PC keep their value to avoid toggling
                bus.ex_valid_o    <= 1'b0;
                bus.ex_instr_id_o <= '0;
                bus.ex_rs1_re_o   <= 1'b0;
                bus.ex_rs2_re_o   <= 1'b0;
                bus.ex_rd_we_o    <= 1'b0;
                bus.ex_mem_re_o   <= 1'b0;
                bus.ex_mem_we_o   <= 1'b0;
                if (load_use && !bus.flush_i && !cnt_sat) begin
                    bus.bubble_cnt_o <= bus.bubble_cnt_o + CNT_W'(1);
                end
            end else begin
                bus.ex_valid_o    <= 1'b1;
                bus.ex_pc_o       <= bus.id_pc_i;
                bus.ex_rs1_addr_o <= bus.id_rs1_addr_i;
                bus.ex_rs2_addr_o <= bus.id_rs2_addr_i;
                bus.ex_rd_addr_o  <= bus.id_rd_addr_i;
                bus.ex_rs1_data_o <= bus.id_rs1_data_i;
                bus.ex_rs2_data_o <= bus.id_rs2_data_i;
                bus.ex_imm_o      <= bus.id_imm_i;
                bus.ex_instr_id_o <= bus.id_instr_id_i;
                bus.ex_rs1_re_o   <= bus.id_rs1_re_i;
                bus.ex_rs2_re_o   <= bus.id_rs2_re_i;
                // Writes to x0 are dropped here so EX/WB never see them
                bus.ex_rd_we_o    <= bus.id_rd_we_i && bus.id_valid_i && (bus.id_rd_addr_i != 5'd0);
                bus.ex_mem_re_o   <= bus.id_mem_re_i && bus.id_valid_i;
                bus.ex_mem_we_o   <= bus.id_mem_we_i && bus.id_valid_i;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, load-use interlock, hold/flush priority, reset, saturation.
// Expected EX contents are queued when stimulus is driven and popped one edge later.
// Stall is checked combinationally half a cycle before each accepting edge.
`ifndef INST_ID_LEN
`define INST_ID_LEN 6
`endif

module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;
    localparam int A_LOAD = 0;
    localparam int A_BUB  = 1;
    localparam int A_HOLD = 2;

    typedef struct packed {
        logic                    valid;
        logic [31:0]             pc;
        logic [4:0]              rs1a, rs2a, rda;
        logic [31:0]             rs1d, rs2d, imm;
        logic [`INST_ID_LEN-1:0] iid;
        logic                    re1, re2, we, mre, mwe;
    } ins_t;

    typedef struct packed {
        logic                    valid;
        logic [31:0]             pc;
        logic [4:0]              rs1a, rs2a, rda;
        logic [31:0]             rs1d, rs2d, imm;
        logic [`INST_ID_LEN-1:0] iid;
        logic                    re1, re2, we, mre, mwe;
        logic [CNT_W-1:0]        cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t got;
    assign got = {bus.ex_valid_o, bus.ex_pc_o, bus.ex_rs1_addr_o, bus.ex_rs2_addr_o, bus.ex_rd_addr_o,
                  bus.ex_rs1_data_o, bus.ex_rs2_data_o, bus.ex_imm_o, bus.ex_instr_id_o,
                  bus.ex_rs1_re_o, bus.ex_rs2_re_o, bus.ex_rd_we_o, bus.ex_mem_re_o, bus.ex_mem_we_o,
                  bus.bubble_cnt_o};

    exp_t sbq[$];
    exp_t model;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic ins_t mk(input logic [31:0] pc, input logic [4:0] rs1a, input logic [4:0] rs2a,
                                input logic [4:0] rda, input logic [31:0] imm, input logic [5:0] iid,
                                input logic re1, input logic re2, input logic we,
                                input logic mre, input logic mwe);
        ins_t r;
        r.valid = 1'b1;
        r.pc = pc; r.rs1a = rs1a; r.rs2a = rs2a; r.rda = rda;
        r.rs1d = pc ^ 32'hA5A5_0000; r.rs2d = pc ^ 32'h0000_5A5A; r.imm = imm;
        r.iid = iid[`INST_ID_LEN-1:0];
        r.re1 = re1; r.re2 = re2; r.we = we; r.mre = mre; r.mwe = mwe;
        return r;
    endfunction

    task automatic drive(input ins_t in, input logic hold, input logic flush);
        bus.id_valid_i    = in.valid;
        bus.id_pc_i       = in.pc;
        bus.id_rs1_addr_i = in.rs1a;
        bus.id_rs2_addr_i = in.rs2a;
        bus.id_rd_addr_i  = in.rda;
        bus.id_rs1_data_i = in.rs1d;
        bus.id_rs2_data_i = in.rs2d;
        bus.id_imm_i      = in.imm;
        bus.id_instr_id_i = in.iid;
        bus.id_rs1_re_i   = in.re1;
        bus.id_rs2_re_i   = in.re2;
        bus.id_rd_we_i    = in.we;
        bus.id_mem_re_i   = in.mre;
        bus.id_mem_we_i   = in.mwe;
        bus.ex_hold_i     = hold;
        bus.flush_i       = flush;
    endtask

    task automatic check_stall(input logic exp_stall, input string tag);
        n_cmp++;
        assert (bus.id_stall_o === exp_stall)
        else begin
            n_err++;
            $error("FAIL %s_stall: got %b expected %b", tag, bus.id_stall_o, exp_stall);
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            n_err++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sbq.pop_front();
            n_cmp++;
            assert (got === e)
            else begin
                n_err++;
                $error("FAIL %s: got %h expected %h", tag, got, e);
            end
            model = e;
        end
    endtask

    // One accepting edge: drive at negedge, check stall, queue expectation, compare after the edge
    task automatic step(input ins_t in, input logic hold, input logic flush, input logic exp_stall,
                        input int act, input int exp_cnt, input string tag);
        exp_t e;
        drive(in, hold, flush);
        #1;
        check_stall(exp_stall, tag);
        e = model;
        if (act == A_LOAD) begin
            e.valid = 1'b1;
            e.pc = in.pc; e.rs1a = in.rs1a; e.rs2a = in.rs2a; e.rda = in.rda;
            e.rs1d = in.rs1d; e.rs2d = in.rs2d; e.imm = in.imm; e.iid = in.iid;
            e.re1 = in.re1; e.re2 = in.re2;
            e.we = in.we & (in.rda != 5'd0);
            e.mre = in.mre; e.mwe = in.mwe;
        end else if (act == A_BUB) begin
            e.valid = 1'b0; e.iid = '0;
            e.re1 = 1'b0; e.re2 = 1'b0; e.we = 1'b0; e.mre = 1'b0; e.mwe = 1'b0;
        end
        e.cnt = exp_cnt[CNT_W-1:0];
        sbq.push_back(e);
        @(posedge clk);
        #1;
        pop_compare(tag);
        @(negedge clk);
    endtask

    task automatic do_reset(input int ncyc, input string tag);
        rst = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            bus.id_valid_i    = 1'($urandom);
            bus.id_pc_i       = $urandom;
            bus.id_rs1_addr_i = 5'($urandom);
            bus.id_rs2_addr_i = 5'($urandom);
            bus.id_rd_addr_i  = 5'($urandom);
            bus.id_rs1_data_i = $urandom;
            bus.id_rs2_data_i = $urandom;
            bus.id_imm_i      = $urandom;
            bus.id_instr_id_i = `INST_ID_LEN'($urandom);
            bus.id_rs1_re_i   = 1'($urandom);
            bus.id_rs2_re_i   = 1'($urandom);
            bus.id_rd_we_i    = 1'($urandom);
            bus.id_mem_re_i   = 1'($urandom);
            bus.id_mem_we_i   = 1'($urandom);
            bus.ex_hold_i     = 1'($urandom);
            bus.flush_i       = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        sbq.push_back('0);
        pop_compare(tag);
        rst = 1'b0;
        bus.ex_hold_i  = 1'b0;
        bus.flush_i    = 1'b0;
        bus.id_valid_i = 1'b0;
        #1;
        check_stall(1'b0, tag);
    endtask

    ins_t addi, lw3, add4, lw0, addx0, lui, sw, lw5, inval;
    int   sat_seq [5] = '{1, 2, 3, 3, 3};

    initial begin
        addi  = mk(32'h100, 5'd1, 5'd0, 5'd5, 32'd7,        6'd1, 1, 0, 1, 0, 0);
        lw3   = mk(32'h104, 5'd2, 5'd0, 5'd3, 32'd16,       6'd2, 1, 0, 1, 1, 0);
        add4  = mk(32'h108, 5'd3, 5'd2, 5'd4, 32'd0,        6'd3, 1, 1, 1, 0, 0);
        lw0   = mk(32'h10c, 5'd2, 5'd0, 5'd0, 32'd4,        6'd2, 1, 0, 1, 1, 0);
        addx0 = mk(32'h110, 5'd0, 5'd0, 5'd6, 32'd0,        6'd3, 1, 1, 1, 0, 0);
        lui   = mk(32'h114, 5'd3, 5'd0, 5'd7, 32'h12345000, 6'd4, 0, 0, 1, 0, 0);
        sw    = mk(32'h118, 5'd8, 5'd2, 5'd0, 32'd12,       6'd5, 1, 1, 0, 0, 1);
        lw5   = mk(32'h11c, 5'd3, 5'd0, 5'd5, 32'd8,        6'd2, 1, 0, 1, 1, 0);
        inval = add4;
        inval.valid = 1'b0;
        inval.rs1a  = 5'd5;
        model = '0;

        do_reset(2, "reset");

        step(addi,  0, 0, 0, A_LOAD, 0, "pass_addi");
        step(lw3,   0, 0, 0, A_LOAD, 0, "lw3");
        step(add4,  0, 0, 1, A_BUB,  1, "lu_bubble");
        step(add4,  0, 0, 0, A_LOAD, 1, "lu_add_latched");
        step(lw0,   0, 0, 0, A_LOAD, 1, "lw_x0");
        step(addx0, 0, 0, 0, A_LOAD, 1, "x0_no_hazard");
        step(lw3,   0, 0, 0, A_LOAD, 1, "lw3_b");
        step(lui,   0, 0, 0, A_LOAD, 1, "lui_no_hazard");
        step(sw,    0, 0, 0, A_LOAD, 1, "store_x0_rd");
        step(addi,  1, 1, 1, A_HOLD, 1, "hold_flush_frozen");
        step(addi,  1, 1, 1, A_HOLD, 1, "hold_flush_frozen2");
        step(addi,  0, 1, 0, A_BUB,  1, "flush_after_hold");
        step(lw3,   0, 0, 0, A_LOAD, 1, "lw3_c");
        step(add4,  0, 1, 0, A_BUB,  1, "flush_beats_lu");
        step(lw3,   0, 0, 0, A_LOAD, 1, "lw3_d");
        step(add4,  1, 0, 1, A_HOLD, 1, "lu_under_hold");
        step(add4,  1, 0, 1, A_HOLD, 1, "lu_under_hold2");
        step(add4,  0, 0, 1, A_BUB,  2, "lu_hold_release");
        step(add4,  0, 0, 0, A_LOAD, 2, "lu_add_after_hold");
        step(lw3,   0, 0, 0, A_LOAD, 2, "lw3_e");
        step(lw5,   0, 0, 1, A_BUB,  3, "b2b_load_bubble");
        step(lw5,   0, 0, 0, A_LOAD, 3, "b2b_load_proceeds");
        step(inval, 0, 0, 0, A_BUB,  3, "invalid_no_count");

        // Reset arriving while a load-use stall is pending
        step(lw3,   0, 0, 0, A_LOAD, 3, "lw3_f");
        drive(add4, 0, 0);
        #1;
        check_stall(1'b1, "pre_reset_stall");
        @(negedge clk);
        do_reset(1, "mid_stall_reset");
        step(add4,  0, 0, 0, A_LOAD, 0, "post_reset_add");

        // Saturation of the 2-bit bubble counter
        for (int i = 0; i < 5; i++) begin
            step(lw3,  0, 0, 0, A_LOAD, (i == 0) ? 0 : sat_seq[i-1], "sat_lw");
            step(add4, 0, 0, 1, A_BUB,  sat_seq[i], "sat_bubble");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

endmodule
